// File: rtl/stopwatch_timer.sv
// rtl/stopwatch_timer.sv - BCD MM:SS stopwatch / countdown timer driven by a sampled 1 Hz tick
// Counts up or down once per tick_clk rising edge, with run/pause/clear/load control.
module stopwatch_timer #(
  parameter int MAX_MIN = 99
) (
  input  logic       in_clk,
  input  logic       rst_n,
  input  logic       tick_clk,
  input  logic       mode,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       load,
  input  logic [6:0] preset_min,
  input  logic [5:0] preset_sec,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  localparam logic [6:0] MAX_MIN_B = 7'(MAX_MIN);

  state_t     state_q, state_d;
  logic       mode_q, mode_d;
  logic       s1, s2, s3;
  logic       tick;
  logic [3:0] mt_d, mo_d, st_d, so_d;
  logic [6:0] cur_min;
  logic [7:0] up_min, dn_min, load_min, load_sec;
  logic [6:0] clamp_min;
  logic [5:0] clamp_sec;
  logic       is_zero, is_one;

  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

  assign tick      = s2 & ~s3;
  assign cur_min   = ({3'b000, min_tens} * 7'd10) + {3'b000, min_ones};
  assign up_min    = (cur_min == MAX_MIN_B) ? 8'h00 : to_bcd(cur_min + 7'd1);
  assign dn_min    = to_bcd(cur_min - 7'd1);
  assign clamp_min = (preset_min > MAX_MIN_B) ? MAX_MIN_B : preset_min;
  assign clamp_sec = (preset_sec > 6'd59) ? 6'd59 : preset_sec;
  assign load_min  = to_bcd(clamp_min);
  assign load_sec  = to_bcd({1'b0, clamp_sec});
  assign is_zero   = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                     (sec_tens == 4'd0) && (sec_ones == 4'd0);
  assign is_one    = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                     (sec_tens == 4'd0) && (sec_ones == 4'd1);

  assign running = (state_q == RUN);
  assign done    = (state_q == DONE);

  always_ff @(posedge in_clk) begin
    if (!rst_n) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
      state_q  <= IDLE;
      mode_q   <= 1'b0;
      min_tens <= 4'd0;
      min_ones <= 4'd0;
      sec_tens <= 4'd0;
      sec_ones <= 4'd0;
    end else begin
      s1       <= tick_clk;
      s2       <= s1;
      s3       <= s2;
      state_q  <= state_d;
      mode_q   <= mode_d;
      min_tens <= mt_d;
      min_ones <= mo_d;
      sec_tens <= st_d;
      sec_ones <= so_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    mt_d    = min_tens;
    mo_d    = min_ones;
    st_d    = sec_tens;
    so_d    = sec_ones;
    if (clear) begin
      {mt_d, mo_d, st_d, so_d} = 16'h0000;
      state_d = IDLE;
    end else if (load) begin
      {mt_d, mo_d} = load_min;
      {st_d, so_d} = load_sec;
      state_d = IDLE;
    end else if (start_stop) begin
      // A same-cycle tick is dropped here by priority, so start and pause never count.
      case (state_q)
        IDLE: begin
          if (!(mode && is_zero)) begin
            mode_d  = mode;
            state_d = RUN;
          end
        end
        RUN:     state_d = PAUSE;
        PAUSE:   state_d = RUN;
        default: state_d = state_q;
      endcase
    end else if (tick && (state_q == RUN)) begin
      if (!mode_q) begin
        if (sec_ones != 4'd9) begin
          so_d = sec_ones + 4'd1;
        end else begin
          so_d = 4'd0;
          if (sec_tens != 4'd5) begin
            st_d = sec_tens + 4'd1;
          end else begin
            st_d = 4'd0;
            {mt_d, mo_d} = up_min;
          end
        end
      end else if (is_zero) begin
        state_d = DONE;
      end else begin
        if (sec_ones != 4'd0) begin
          so_d = sec_ones - 4'd1;
        end else begin
          so_d = 4'd9;
          if (sec_tens != 4'd0) begin
            st_d = sec_tens - 4'd1;
          end else begin
            st_d = 4'd5;
            {mt_d, mo_d} = dn_min;
          end
        end
        if (is_one) state_d = DONE;
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_timer.sv
// tb/tb_stopwatch_timer.sv - self-checking bench for stopwatch_timer against a seconds-count model
// The model keeps time as an integer number of seconds and derives the expected digits from it.
module tb_stopwatch_timer;

  localparam int MAXM   = 99;
  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_PAUS = 2;
  localparam int S_DONE = 3;

  logic       in_clk = 1'b0;
  logic       rst_n, tick_clk, mode, start_stop, clear, load;
  logic [6:0] preset_min;
  logic [5:0] preset_sec;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       running, done;

  int vectors = 0;
  int miscompares = 0;

  int m_sec = 0;
  int m_st = S_IDLE;
  int m_mq = 0;
  int m_pm, m_ps;
  bit h0, h1, h2, m_tk;

  stopwatch_timer #(.MAX_MIN(MAXM)) dut (
    .in_clk(in_clk), .rst_n(rst_n), .tick_clk(tick_clk), .mode(mode),
    .start_stop(start_stop), .clear(clear), .load(load),
    .preset_min(preset_min), .preset_sec(preset_sec),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .running(running), .done(done)
  );

  always #5 in_clk = ~in_clk;

  // A tick_clk rise first sampled at edge E takes effect at edge E+2.
  always @(posedge in_clk) begin
    if (!rst_n) begin
      m_sec = 0; m_st = S_IDLE; m_mq = 0;
      h0 = 0; h1 = 0; h2 = 0;
    end else begin
      m_tk = h1 && !h2;
      h2 = h1; h1 = h0; h0 = tick_clk;
      if (clear) begin
        m_sec = 0; m_st = S_IDLE;
      end else if (load) begin
        m_pm = (int'(preset_min) > MAXM) ? MAXM : int'(preset_min);
        m_ps = (int'(preset_sec) > 59) ? 59 : int'(preset_sec);
        m_sec = m_pm * 60 + m_ps;
        m_st = S_IDLE;
      end else if (start_stop) begin
        if (m_st == S_IDLE) begin
          if (!(mode && m_sec == 0)) begin m_mq = int'(mode); m_st = S_RUN; end
        end else if (m_st == S_RUN) m_st = S_PAUS;
        else if (m_st == S_PAUS) m_st = S_RUN;
      end else if (m_tk && m_st == S_RUN) begin
        if (m_mq == 0) m_sec = (m_sec + 1) % ((MAXM + 1) * 60);
        else begin
          if (m_sec > 0) m_sec = m_sec - 1;
          if (m_sec == 0) m_st = S_DONE;
        end
      end
    end
  end

  function automatic logic [17:0] expv();
    int mm, ss;
    mm = m_sec / 60;
    ss = m_sec % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10),
            m_st == S_RUN, m_st == S_DONE};
  endfunction

  function automatic logic [17:0] obs();
    return {min_tens, min_ones, sec_tens, sec_ones, running, done};
  endfunction

  task automatic cyc();
    @(negedge in_clk);
    vectors++;
    assert (obs() === expv()) else begin
      miscompares++;
      $error("FAIL model t=%0t: observed %h expected %h", $time, obs(), expv());
    end
  endtask

  task automatic chk(input string tag, input logic [17:0] exp);
    vectors++;
    assert (obs() === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs(), exp);
    end
  endtask

  task automatic do_ss();
    start_stop = 1'b1; cyc(); start_stop = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1; cyc(); clear = 1'b0;
  endtask

  task automatic do_load(input int pm, input int ps);
    preset_min = 7'(pm); preset_sec = 6'(ps);
    load = 1'b1; cyc(); load = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick_clk = 1'b1; repeat (3) cyc();
      tick_clk = 1'b0; repeat (3) cyc();
    end
  endtask

  initial begin
    int first;
    int hold;
    rst_n = 1'b0; tick_clk = 1'b0; mode = 1'b0; start_stop = 1'b0;
    clear = 1'b0; load = 1'b0; preset_min = 7'd0; preset_sec = 6'd0;

    repeat (6) begin tick_clk = ~tick_clk; cyc(); end
    chk("reset", {16'h0000, 2'b00});
    rst_n = 1'b1;
    ticks(5);
    chk("idle_ticks", {16'h0000, 2'b00});

    do_ss();
    ticks(61);
    chk("carry_61", {16'h0101, 2'b10});
    do_ss();
    ticks(3);
    chk("paused", {16'h0101, 2'b00});
    do_ss();
    ticks(1);
    chk("resumed", {16'h0102, 2'b10});

    do_clear();
    do_ss();
    ticks(99 * 60 + 59);
    chk("max_count", {16'h9959, 2'b10});
    ticks(1);
    chk("wrap", {16'h0000, 2'b10});

    do_clear();
    mode = 1'b1;
    do_load(1, 5);
    chk("load_105", {16'h0105, 2'b00});
    do_ss();
    ticks(1);
    chk("timer_104", {16'h0104, 2'b10});
    ticks(5);
    chk("timer_059", {16'h0059, 2'b10});
    ticks(58);
    chk("timer_001", {16'h0001, 2'b10});
    ticks(1);
    chk("expired", {16'h0000, 2'b01});
    ticks(1);
    chk("done_hold", {16'h0000, 2'b01});
    do_ss();
    chk("done_ss", {16'h0000, 2'b01});
    do_load(1, 63);
    chk("sec_clamp", {16'h0159, 2'b00});
    do_load(120, 10);
    chk("min_clamp", {16'h9910, 2'b00});

    do_clear();
    mode = 1'b1;
    do_ss();
    chk("empty_timer", {16'h0000, 2'b00});
    mode = 1'b0;
    do_ss();
    mode = 1'b1;
    ticks(2);
    chk("mode_change", {16'h0002, 2'b10});

    preset_min = 7'd5; preset_sec = 6'd5;
    clear = 1'b1; load = 1'b1; start_stop = 1'b1;
    cyc();
    clear = 1'b0; load = 1'b0; start_stop = 1'b0;
    chk("simultaneous", {16'h0000, 2'b00});

    mode = 1'b0;
    do_ss();
    ticks(3);
    tick_clk = 1'b1; cyc(); cyc();
    start_stop = 1'b1; cyc(); start_stop = 1'b0;
    chk("pause_tick", {16'h0003, 2'b00});
    tick_clk = 1'b0; repeat (3) cyc();
    do_ss();

    tick_clk = 1'b1;
    first = -1;
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (first < 0 && obs() !== {16'h0003, 2'b10}) first = k;
    end
    vectors++;
    assert (first === 2) else begin
      miscompares++;
      $error("FAIL tick_latency: observed edge E0+%0d expected edge E0+2", first);
    end
    chk("latency_val", {16'h0004, 2'b10});
    tick_clk = 1'b0; repeat (3) cyc();

    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    chk("reset_mid_run", {16'h0000, 2'b00});

    hold = 0;
    repeat (4000) begin
      start_stop = ($urandom_range(0, 29) == 0);
      clear      = ($urandom_range(0, 299) == 0);
      load       = ($urandom_range(0, 99) == 0);
      rst_n      = ($urandom_range(0, 999) != 0);
      if ($urandom_range(0, 19) == 0) mode = 1'($urandom_range(0, 1));
      preset_min = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(0, 127)) : 7'd0;
      preset_sec = 6'($urandom_range(0, 63));
      hold++;
      if (hold >= 3 && $urandom_range(0, 1) == 1) begin
        tick_clk = ~tick_clk;
        hold = 0;
      end
      cyc();
    end
    start_stop = 1'b0; clear = 1'b0; load = 1'b0; rst_n = 1'b1;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
